// File: rtl/mem_wb_skid_reg.sv
// MEM->WB stage register with valid/ready handshake and a two-entry skid buffer.
// Main entry M drives the write-back port; skid entry S absorbs one entry when WB stalls.
module mem_wb_skid_reg #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_wD,
  input  logic [REG_AW-1:0] in_wR,
  input  logic              in_rf_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wD,
  output logic [REG_AW-1:0] out_wR,
  output logic              out_rf_we,
  output logic [1:0]        occ
);

  logic              m_vld, s_vld;
  logic [DATA_W-1:0] m_wD, s_wD;
  logic [REG_AW-1:0] m_wR, s_wR;
  logic              m_we, s_we;
  logic              accept, drain, cap_we;

  // Writes to register 0 are dropped at capture so they never reach the regfile.
  function automatic logic gate_we(input logic we, input logic [REG_AW-1:0] wr);
    return we & !((ZERO_SUPPRESS != 0) && (wr == '0));
  endfunction

  assign in_ready  = !s_vld;
  assign accept    = in_valid & in_ready;
  assign drain     = m_vld & out_ready;
  assign cap_we    = gate_we(in_rf_we, in_wR);

  assign out_valid = m_vld;
  assign out_wD    = m_wD;
  assign out_wR    = m_wR;
  assign out_rf_we = m_we & m_vld;
  assign occ       = {1'b0, m_vld} + {1'b0, s_vld};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_wD  <= '0;
      m_wR  <= '0;
      m_we  <= 1'b0;
      s_wD  <= '0;
      s_wR  <= '0;
      s_we  <= 1'b0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (drain || !m_vld) begin
      if (s_vld) begin
        m_vld <= 1'b1;
        m_wD  <= s_wD;
        m_wR  <= s_wR;
        m_we  <= s_we;
        s_vld <= 1'b0;
      end else begin
        m_vld <= accept;
        if (accept) begin
          m_wD <= in_wD;
          m_wR <= in_wR;
          m_we <= cap_we;
        end
      end
    end else if (accept) begin
      // M is held by WB: park the new entry in the skid slot.
      s_vld <= 1'b1;
      s_wD  <= in_wD;
      s_wR  <= in_wR;
      s_we  <= cap_we;
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: hand-computed vector table, random traffic against a
// queue-based reference, and an asynchronous reset while full.
module tb_mem_wb_skid_reg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_rf_we, out_ready;
  logic [DATA_W-1:0] in_wD;
  logic [REG_AW-1:0] in_wR;
  logic              in_ready, out_valid, out_rf_we;
  logic [DATA_W-1:0] out_wD;
  logic [REG_AW-1:0] out_wR;
  logic [1:0]        occ;
  logic              in_ready_z, out_valid_z, out_rf_we_z;
  logic [DATA_W-1:0] out_wD_z;
  logic [REG_AW-1:0] out_wR_z;
  logic [1:0]        occ_z;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wD(in_wD), .in_wR(in_wR), .in_rf_we(in_rf_we), .out_valid(out_valid),
    .out_ready(out_ready), .out_wD(out_wD), .out_wR(out_wR), .out_rf_we(out_rf_we),
    .occ(occ));

  mem_wb_skid_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_SUPPRESS(0)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_wD(in_wD), .in_wR(in_wR), .in_rf_we(in_rf_we), .out_valid(out_valid_z),
    .out_ready(out_ready), .out_wD(out_wD_z), .out_wR(out_wR_z), .out_rf_we(out_rf_we_z),
    .occ(occ_z));

  typedef struct {
    logic              flush, iv;
    logic [DATA_W-1:0] wd;
    logic [REG_AW-1:0] wr;
    logic              we, ordy;
    logic              e_ov;
    logic [DATA_W-1:0] e_wd;
    logic [REG_AW-1:0] e_wr;
    logic              e_we, e_we0;
    logic [1:0]        e_occ;
    logic              e_ir;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] wd;
    logic [REG_AW-1:0] wr;
    logic              we;
  } ent_t;

  vec_t tbl[20];
  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, iv, input logic [31:0] wd, input logic [4:0] wr,
                              input logic we, ordy, e_ov, input logic [31:0] e_wd,
                              input logic [4:0] e_wr, input logic e_we, e_we0,
                              input logic [1:0] e_occ, input logic e_ir);
    vec_t v;
    v.flush = fl; v.iv = iv; v.wd = wd; v.wr = wr; v.we = we; v.ordy = ordy;
    v.e_ov = e_ov; v.e_wd = e_wd; v.e_wr = e_wr; v.e_we = e_we; v.e_we0 = e_we0;
    v.e_occ = e_occ; v.e_ir = e_ir;
    return v;
  endfunction

  // Expected outputs follow directly from the queue contents.
  task automatic check_model(input int cyc);
    logic ev;
    ev = (q.size() > 0);
    chk($sformatf("rnd%0d ov", cyc), 64'(out_valid), 64'(ev));
    chk($sformatf("rnd%0d occ", cyc), 64'(occ), 64'(q.size()));
    chk($sformatf("rnd%0d ir", cyc), 64'(in_ready), 64'(q.size() < 2));
    chk($sformatf("rnd%0d occ_z", cyc), 64'(occ_z), 64'(q.size()));
    if (ev) begin
      chk($sformatf("rnd%0d wd", cyc), 64'(out_wD), 64'(q[0].wd));
      chk($sformatf("rnd%0d wr", cyc), 64'(out_wR), 64'(q[0].wr));
      chk($sformatf("rnd%0d we", cyc), 64'(out_rf_we), 64'(q[0].we && (q[0].wr != 0)));
      chk($sformatf("rnd%0d we_z", cyc), 64'(out_rf_we_z), 64'(q[0].we));
      chk($sformatf("rnd%0d wd_z", cyc), 64'(out_wD_z), 64'(q[0].wd));
    end else begin
      chk($sformatf("rnd%0d we", cyc), 64'(out_rf_we), 64'd0);
      chk($sformatf("rnd%0d we_z", cyc), 64'(out_rf_we_z), 64'd0);
    end
  endtask

  task automatic model_step();
    ent_t e;
    logic dr, acc;
    if (flush) begin
      q.delete();
    end else begin
      dr  = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (dr) void'(q.pop_front());
      if (acc) begin
        e.wd = in_wD; e.wr = in_wR; e.we = in_rf_we;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic stall;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_wD = '0; in_wR = '0;
    in_rf_we = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset ov", 64'(out_valid), 64'd0);
    chk("reset occ", 64'(occ), 64'd0);
    chk("reset ir", 64'(in_ready), 64'd1);
    chk("reset wd", 64'(out_wD), 64'd0);
    @(negedge clk); rst = 1'b0;

    //             fl iv wd            wr we ordy ov  e_wd          e_wr we we0 occ ir
    tbl[0]  = mk(0, 1, 32'h11,        1, 1, 1,   0, 32'h0,        0, 0, 0,  0, 1);
    tbl[1]  = mk(0, 1, 32'h12,        2, 1, 1,   1, 32'h11,       1, 1, 1,  1, 1);
    tbl[2]  = mk(0, 1, 32'h13,        3, 1, 1,   1, 32'h12,       2, 1, 1,  1, 1);
    tbl[3]  = mk(0, 1, 32'h14,        4, 1, 1,   1, 32'h13,       3, 1, 1,  1, 1);
    tbl[4]  = mk(0, 0, 32'h0,         0, 0, 1,   1, 32'h14,       4, 1, 1,  1, 1);
    tbl[5]  = mk(0, 1, 32'hAAAA0001,  3, 1, 0,   0, 32'h0,        0, 0, 0,  0, 1);
    tbl[6]  = mk(0, 1, 32'hBBBB0002,  4, 1, 0,   1, 32'hAAAA0001, 3, 1, 1,  1, 1);
    tbl[7]  = mk(0, 1, 32'hCCCC0003,  5, 1, 0,   1, 32'hAAAA0001, 3, 1, 1,  2, 0);
    tbl[8]  = mk(0, 1, 32'hCCCC0003,  5, 1, 1,   1, 32'hAAAA0001, 3, 1, 1,  2, 0);
    tbl[9]  = mk(0, 1, 32'hCCCC0003,  5, 1, 1,   1, 32'hBBBB0002, 4, 1, 1,  1, 1);
    tbl[10] = mk(0, 0, 32'h0,         0, 0, 1,   1, 32'hCCCC0003, 5, 1, 1,  1, 1);
    tbl[11] = mk(0, 1, 32'hDEADBEEF,  0, 1, 0,   0, 32'h0,        0, 0, 0,  0, 1);
    tbl[12] = mk(0, 0, 32'h0,         0, 0, 0,   1, 32'hDEADBEEF, 0, 0, 1,  1, 1);
    tbl[13] = mk(0, 1, 32'h55,        7, 1, 1,   1, 32'hDEADBEEF, 0, 0, 1,  1, 1);
    tbl[14] = mk(0, 1, 32'h66,        8, 0, 0,   1, 32'h55,       7, 1, 1,  1, 1);
    tbl[15] = mk(1, 1, 32'h77,        9, 1, 0,   1, 32'h55,       7, 1, 1,  2, 0);
    tbl[16] = mk(0, 0, 32'h0,         0, 0, 1,   0, 32'h0,        0, 0, 0,  0, 1);
    tbl[17] = mk(0, 1, 32'h88,       10, 1, 1,   0, 32'h0,        0, 0, 0,  0, 1);
    tbl[18] = mk(0, 0, 32'h0,         0, 0, 1,   1, 32'h88,      10, 1, 1,  1, 1);
    tbl[19] = mk(0, 0, 32'h0,         0, 0, 1,   0, 32'h0,        0, 0, 0,  0, 1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flush = tbl[i].flush; in_valid = tbl[i].iv; in_wD = tbl[i].wd; in_wR = tbl[i].wr;
      in_rf_we = tbl[i].we; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d ov", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d occ", i), 64'(occ), 64'(tbl[i].e_occ));
      chk($sformatf("vec%0d ir", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("vec%0d we", i), 64'(out_rf_we), 64'(tbl[i].e_we));
      chk($sformatf("vec%0d we_z", i), 64'(out_rf_we_z), 64'(tbl[i].e_we0));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d wd", i), 64'(out_wD), 64'(tbl[i].e_wd));
        chk($sformatf("vec%0d wr", i), 64'(out_wR), 64'(tbl[i].e_wr));
      end
    end

    // Random traffic; upstream holds its offer while stalled.
    q.delete();
    stall = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!stall) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_wD    = $urandom;
        in_wR    = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
        in_rf_we = ($urandom_range(0, 3) != 0);
      end
      #1;
      check_model(c);
      stall = in_valid && !in_ready && !flush;
      @(posedge clk);
      model_step();
    end

    // Fill to two entries, then assert reset asynchronously mid-cycle.
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_wD = 32'h1234; in_wR = 6; in_rf_we = 1'b1;
    @(negedge clk);
    in_wD = 32'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-rst occ", 64'(occ), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst ov", 64'(out_valid), 64'd0);
    chk("rst we", 64'(out_rf_we), 64'd0);
    chk("rst occ", 64'(occ), 64'd0);
    chk("rst wd", 64'(out_wD), 64'd0);
    chk("rst wr", 64'(out_wR), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_wD = 32'h9999; in_wR = 2; in_rf_we = 1'b1; out_ready = 1'b1;
    #1;
    chk("post-rst ir", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post-rst ov", 64'(out_valid), 64'd1);
    chk("post-rst wd", 64'(out_wD), 64'h9999);
    chk("post-rst we", 64'(out_rf_we), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
